// File: rtl/output_uart.sv
// Q-register tap: a byte FIFO feeding an 8N1 serial transmitter, LSB first.
// Define OUTPUT_UART_PARITY_EN to add an even-parity bit (8E1 framing).
module output_uart #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          triggerQ,
  input  logic [7:0]                    qreg,
  output logic                          tx,
  output logic                          busy,
  output logic                          full,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
`ifdef OUTPUT_UART_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [2:0]    state;
  logic [BW-1:0] baud;
  logic [2:0]    bitIdx;
  logic [7:0]    shifter;
`ifdef OUTPUT_UART_PARITY_EN
  logic          parityBit;
`endif

  logic baudDone;
  logic notEmpty;
  logic pop;
  logic push;

  assign baudDone = baud == BW'(CLKS_PER_BIT - 1);
  assign notEmpty = count != '0;
  assign full     = count == (PW + 1)'(FIFO_DEPTH);
  assign busy     = (state != IDLE) || notEmpty;

  // Pops only happen at frame start, so a full FIFO still accepts a write then.
  assign pop  = notEmpty && ((state == IDLE) || (state == STOP && baudDone));
  assign push = triggerQ && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= qreg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (triggerQ && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      baud      <= '0;
      bitIdx    <= '0;
      shifter   <= '0;
      tx        <= 1'b1;
`ifdef OUTPUT_UART_PARITY_EN
      parityBit <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            state <= START;
            baud  <= '0;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (baudDone) begin
            state  <= DATA;
            baud   <= '0;
            bitIdx <= '0;
            tx     <= shifter[0];
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (baudDone) begin
            baud <= '0;
            if (bitIdx == 3'd7) begin
`ifdef OUTPUT_UART_PARITY_EN
              state <= PARITY;
              tx    <= parityBit;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              shifter <= shifter >> 1;
              bitIdx  <= bitIdx + 1'b1;
              tx      <= shifter[1];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
`ifdef OUTPUT_UART_PARITY_EN
        PARITY: begin
          if (baudDone) begin
            state <= STOP;
            baud  <= '0;
            tx    <= 1'b1;
          end else begin
            baud <= baud + 1'b1;
          end
        end
`endif
        STOP: begin
          if (baudDone) begin
            baud <= '0;
            if (pop) begin
              state <= START;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
      // Head byte is captured whenever a frame starts, from IDLE or STOP.
      if (pop) begin
        shifter   <= mem[rdPtr];
`ifdef OUTPUT_UART_PARITY_EN
        parityBit <= ^mem[rdPtr];
`endif
      end
    end
  end

endmodule
